// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter merging CHANNELS AXI-stream inputs into one registered output.
// A grant is held from the first beat of a packet through its ilast beat.
module axis_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 4,
    parameter int CHAN_WIDTH = 2
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic [CHANNELS*DATA_WIDTH-1:0] idata,
    input  logic [CHANNELS-1:0]            ilast,
    input  logic [CHANNELS-1:0]            ivalid,
    output logic [CHANNELS-1:0]            iready,
    output logic [DATA_WIDTH-1:0]          odata,
    output logic                           olast,
    output logic [CHAN_WIDTH-1:0]          ochan,
    output logic                           ovalid,
    input  logic                           oready
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic [CHAN_WIDTH-1:0]   grant_r, grant_s;
    logic [CHAN_WIDTH-1:0]   prio_r, prio_s;
    logic [CHAN_WIDTH-1:0]   pick_s, grant_inc_s;
    logic [CHANNELS-1:0]     iready_s;
    logic                    out_free_s, in_xfer_s;
    logic [DATA_WIDTH-1:0]   gdata_s;
    logic [DATA_WIDTH-1:0]   odata_r, odata_s;
    logic                    olast_r, olast_s;
    logic [CHAN_WIDTH-1:0]   ochan_r, ochan_s;
    logic                    ovalid_r, ovalid_s;

    // Rotate requests so bit 0 is the priority channel, take the lowest set bit, rotate back.
    function automatic logic [CHAN_WIDTH-1:0] rr_pick(input logic [CHANNELS-1:0]   req,
                                                      input logic [CHAN_WIDTH-1:0] start);
        logic [2*CHANNELS-1:0] rot;
        logic [CHAN_WIDTH-1:0] off;
        logic [CHAN_WIDTH:0]   sum;
        logic                  found;
        rot   = {req, req} >> start;
        off   = {CHAN_WIDTH{1'b0}};
        found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && rot[i]) begin
                off   = CHAN_WIDTH'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (CHAN_WIDTH+1)'(CHANNELS)) begin
            sum = sum - (CHAN_WIDTH+1)'(CHANNELS);
        end else begin
            sum = sum;
        end
        return sum[CHAN_WIDTH-1:0];
    endfunction

    assign out_free_s  = !ovalid_r || oready;
    assign in_xfer_s   = (state_r == ST_LOCKED) && ivalid[grant_r] && out_free_s;
    assign gdata_s     = idata[grant_r*DATA_WIDTH +: DATA_WIDTH];
    assign grant_inc_s = (grant_r == CHAN_WIDTH'(CHANNELS-1)) ? {CHAN_WIDTH{1'b0}}
                                                              : grant_r + CHAN_WIDTH'(1);

    // Arbitration choice and per-channel ready.
    always_comb begin
        pick_s   = rr_pick(ivalid, prio_r);
        iready_s = {CHANNELS{1'b0}};
        if (state_r == ST_LOCKED) begin
            iready_s[grant_r] = out_free_s;
        end else begin
            iready_s = {CHANNELS{1'b0}};
        end
    end

    // Next-state logic: IDLE arbitrates, LOCKED runs until the ilast beat is accepted.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        prio_s  = prio_r;
        case (state_r)
            ST_IDLE: begin
                if (|ivalid) begin
                    grant_s = pick_s;
                    state_s = ST_LOCKED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (in_xfer_s && ilast[grant_r]) begin
                    state_s = ST_IDLE;
                    prio_s  = grant_inc_s;
                end else begin
                    state_s = ST_LOCKED;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = {CHAN_WIDTH{1'b0}};
                prio_s  = {CHAN_WIDTH{1'b0}};
            end
        endcase
    end

    // Output register: load on input transfer, otherwise hold until drained.
    always_comb begin
        odata_s  = odata_r;
        olast_s  = olast_r;
        ochan_s  = ochan_r;
        ovalid_s = ovalid_r;
        if (in_xfer_s) begin
            odata_s  = gdata_s;
            olast_s  = ilast[grant_r];
            ochan_s  = grant_r;
            ovalid_s = 1'b1;
        end else begin
            ovalid_s = ovalid_r && !oready;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r  <= ST_IDLE;
            grant_r  <= {CHAN_WIDTH{1'b0}};
            prio_r   <= {CHAN_WIDTH{1'b0}};
            odata_r  <= {DATA_WIDTH{1'b0}};
            olast_r  <= 1'b0;
            ochan_r  <= {CHAN_WIDTH{1'b0}};
            ovalid_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            grant_r  <= grant_s;
            prio_r   <= prio_s;
            odata_r  <= odata_s;
            olast_r  <= olast_s;
            ochan_r  <= ochan_s;
            ovalid_r <= ovalid_s;
        end
    end

    assign iready = iready_s;
    assign odata  = odata_r;
    assign olast  = olast_r;
    assign ochan  = ochan_r;
    assign ovalid = ovalid_r;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: expected beats are queued in arbitration order as
// packets are loaded, and compared against each output transfer.
module tb_axis_rr_arbiter;

    localparam int DW = 8;
    localparam int CH = 4;
    localparam int CW = 2;

    logic              clock = 1'b0;
    logic              resetn;
    logic [CH*DW-1:0]  idata;
    logic [CH-1:0]     ilast, ivalid, iready;
    logic [DW-1:0]     odata;
    logic              olast;
    logic [CW-1:0]     ochan;
    logic              ovalid, oready;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [CW-1:0] chan;
    } beat_t;

    beat_t         src_q[CH][$];
    beat_t         exp_q[$];
    int            out_cyc_q[$];
    int            gap_at[CH];
    int            gap_len[CH];
    logic [CH-1:0] fire;
    logic          oready_v;
    int            cyc;
    int            n_checks;
    int            n_errors;

    axis_rr_arbiter #(.DATA_WIDTH(DW), .CHANNELS(CH), .CHAN_WIDTH(CW)) dut (
        .clock  (clock),
        .resetn (resetn),
        .idata  (idata),
        .ilast  (ilast),
        .ivalid (ivalid),
        .iready (iready),
        .odata  (odata),
        .olast  (olast),
        .ochan  (ochan),
        .ovalid (ovalid),
        .oready (oready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: retire last cycle's accepted beats, drive sources, then score any output transfer.
    task automatic step();
        beat_t b;
        @(negedge clock);
        cyc++;
        for (int k = 0; k < CH; k++) begin
            if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        end
        for (int k = 0; k < CH; k++) begin
            ivalid[k] = 1'b0;
            ilast[k]  = 1'b0;
            idata[k*DW +: DW] = '0;
            if (src_q[k].size() > 0) begin
                if (src_q[k].size() == gap_at[k] && gap_len[k] > 0) begin
                    gap_len[k]--;
                end else begin
                    b = src_q[k][0];
                    ivalid[k] = 1'b1;
                    ilast[k]  = b.last;
                    idata[k*DW +: DW] = b.data;
                end
            end
        end
        oready = oready_v;
        #1;
        fire = ivalid & iready;
        chk("iready_onehot", 32'($countones(iready) <= 1), 32'd1);
        if (ovalid && oready) begin
            chk("exp_avail", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                chk("odata", 32'(odata), 32'(b.data));
                chk("olast", 32'(olast), 32'(b.last));
                chk("ochan", 32'(ochan), 32'(b.chan));
            end
            out_cyc_q.push_back(cyc);
        end
    endtask

    task automatic load_pkt(input int ch, input int n, input logic [DW-1:0] base);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + DW'(i);
            b.last = (i == n - 1);
            b.chan = CW'(ch);
            src_q[ch].push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Asserts reset at the current instant, checks the reset state and clears the bench model.
    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_ovalid", 32'(ovalid), 32'd0);
        chk("rst_iready", 32'(iready), 32'd0);
        chk("rst_odata",  32'(odata),  32'd0);
        chk("rst_olast",  32'(olast),  32'd0);
        chk("rst_ochan",  32'(ochan),  32'd0);
        for (int k = 0; k < CH; k++) begin
            src_q[k].delete();
            gap_at[k]  = 0;
            gap_len[k] = 0;
        end
        exp_q.delete();
        out_cyc_q.delete();
        fire   = '0;
        ivalid = '0;
        ilast  = '0;
        idata  = '0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        #1;
        chk("idle_iready", 32'(iready), 32'd0);
    endtask

    task automatic chk_spacing(input string tag, input int idx, input int exp_gap);
        if (out_cyc_q.size() > idx) chk(tag, 32'(out_cyc_q[idx] - out_cyc_q[idx-1]), 32'(exp_gap));
        else chk({tag, "_missing"}, 32'(out_cyc_q.size()), 32'(idx + 1));
    endtask

    initial begin
        int start;
        int n;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        resetn   = 1'b1;
        ivalid   = '0;
        ilast    = '0;
        idata    = '0;
        oready   = 1'b0;
        oready_v = 1'b1;
        fire     = '0;
        @(negedge clock);

        // 1: single 3-beat packet on ch0, two-cycle latency then back-to-back beats
        do_reset();
        load_pkt(0, 3, 8'hA0);
        start = cyc + 1;
        drain("t1", 20);
        chk("t1_nbeats", 32'(out_cyc_q.size()), 32'd3);
        if (out_cyc_q.size() > 0) chk("t1_latency", 32'(out_cyc_q[0] - start), 32'd2);
        chk_spacing("t1_gap1", 1, 1);
        chk_spacing("t1_gap2", 2, 1);

        // 2: all channels, two 2-beat packets each, strict rotation with one bubble between packets
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < CH; c++)
                load_pkt(c, 2, 8'h40 + DW'(r * 32 + c * 4));
        drain("t2", 60);
        chk("t2_nbeats", 32'(out_cyc_q.size()), 32'd16);
        for (int i = 1; i < 16; i++) chk_spacing("t2_gap", i, (i % 2 == 1) ? 1 : 2);

        // 5: simultaneous single-beat packets on ch1 and ch3
        do_reset();
        load_pkt(1, 1, 8'hB1);
        load_pkt(3, 1, 8'hB3);
        drain("t5", 20);
        chk_spacing("t5_gap", 1, 2);

        // 3: downstream stall mid-packet on ch2
        do_reset();
        load_pkt(2, 4, 8'hC0);
        n = 0;
        while (out_cyc_q.size() < 1 && n < 20) begin
            step();
            n++;
        end
        chk("t3_first_out", 32'(out_cyc_q.size()), 32'd1);
        oready_v = 1'b0;
        repeat (5) begin
            step();
            chk("t3_ovalid", 32'(ovalid), 32'd1);
            chk("t3_odata",  32'(odata), 32'(exp_q[0].data));
            chk("t3_iready", 32'(iready), 32'd0);
        end
        oready_v = 1'b1;
        drain("t3", 20);
        chk("t3_nbeats", 32'(out_cyc_q.size()), 32'd4);

        // 4: prio now 3; ch0 wins over ch2 by wrap, and its mid-packet ivalid gap does not let ch2 in
        gap_at[0]  = 2;
        gap_len[0] = 3;
        load_pkt(0, 3, 8'hD0);
        load_pkt(2, 2, 8'hD8);
        drain("t4", 40);

        // 6: reset after the second beat of a 4-beat ch1 packet; afterwards ch0 beats ch3
        load_pkt(1, 4, 8'hE0);
        n = 0;
        while (src_q[1].size() != 2 && n < 20) begin
            step();
            n++;
        end
        chk("t6_two_accepted", 32'(src_q[1].size()), 32'd2);
        do_reset();
        load_pkt(0, 1, 8'hF0);
        load_pkt(3, 1, 8'hF3);
        drain("t6", 20);
        chk_spacing("t6_gap", 1, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
